banner_scroll_ctrl: RTL and testbench

- Sequences a row of N_CHARS glyph renderers, such as a "GAME OVER" banner, across the 640-wide playfield.
- Per frame, produces the shared glyph origin (base_x, base_y). Top level places glyph i at base_x + i*pitch.
- Gates the OR of the renderers' pixel outputs into one display bit.
- Frame-paced FSM: scroll in from the right edge, hold (optionally blinking), scroll back out right, signal done.

---
 rtl/banner_scroll_ctrl.sv | 163 ++++++++++++++++
 tb/tb_banner_scroll_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/banner_scroll_ctrl.sv
// Frame-paced banner sequencer: scrolls a glyph row in from the right, holds it, then scrolls it back out.
// Optional blinking during HOLD is enabled by defining BANNER_BLINK_EN.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | banner parked at SCREEN_W, hidden, waiting for start
// S_SCROLL_IN| moving left by SCROLL_STEP per frame until TARGET_X
// S_HOLD     | resting at TARGET_X for HOLD_FRAMES frames (may blink)
// S_SCROLL_OUT| moving right by SCROLL_STEP per frame until SCREEN_W, then done
module banner_scroll_ctrl #(
   parameter int N_CHARS      = 4,
   parameter int SCREEN_W     = 640,
   parameter int TARGET_X     = 250,
   parameter int TARGET_Y     = 220,
   parameter int SCROLL_STEP  = 8,
   parameter int HOLD_FRAMES  = 120,
   parameter int BLINK_FRAMES = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic               start,
   input  logic               abort,
   input  logic [N_CHARS-1:0] glyph_on,
   output logic [9:0]         base_x,
   output logic [9:0]         base_y,
   output logic               display,
   output logic               busy,
   output logic               done
);

   localparam logic [1:0] S_IDLE       = 2'd0;
   localparam logic [1:0] S_SCROLL_IN  = 2'd1;
   localparam logic [1:0] S_HOLD       = 2'd2;
   localparam logic [1:0] S_SCROLL_OUT = 2'd3;

   localparam int HOLD_W  = $clog2(HOLD_FRAMES + 1);
   localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

   localparam logic [9:0]        SCR_X     = 10'(SCREEN_W);
   localparam logic [9:0]        TGT_X     = 10'(TARGET_X);
   localparam logic [9:0]        TGT_Y     = 10'(TARGET_Y);
   localparam logic [9:0]        STEP_X    = 10'(SCROLL_STEP);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

   if (TARGET_X >= SCREEN_W) begin : g_chk_target
      $error("banner_scroll_ctrl: TARGET_X must be below SCREEN_W");
   end
   if (SCROLL_STEP < 1) begin : g_chk_step
      $error("banner_scroll_ctrl: SCROLL_STEP must be at least 1");
   end
   if (HOLD_FRAMES < 1) begin : g_chk_hold
      $error("banner_scroll_ctrl: HOLD_FRAMES must be at least 1");
   end
   if (BLINK_FRAMES < 1) begin : g_chk_blink
      $error("banner_scroll_ctrl: BLINK_FRAMES must be at least 1");
   end

   logic [1:0]        state;
   logic              visible;
   logic [HOLD_W-1:0] hold_cnt;
   logic [9:0]        dist_in;
   logic [9:0]        dist_out;

`ifdef BANNER_BLINK_EN
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
   logic [BLINK_W-1:0] blink_cnt;
`endif

   // Distances are taken before stepping so base_x can never wrap past either end.
   assign dist_in  = base_x - TGT_X;
   assign dist_out = SCR_X - base_x;

   assign base_y  = TGT_Y;
   assign busy    = (state != S_IDLE);
   assign display = visible & (|glyph_on);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         base_x   <= SCR_X;
         visible  <= 1'b0;
         hold_cnt <= '0;
         done     <= 1'b0;
`ifdef BANNER_BLINK_EN
         blink_cnt <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               base_x  <= SCR_X;
               visible <= 1'b0;
               if (start && !abort) begin
                  state   <= S_SCROLL_IN;
                  visible <= 1'b1;
               end
            end

            S_SCROLL_IN: begin
               if (abort) begin
                  state   <= S_SCROLL_OUT;
                  visible <= 1'b1;
               end else if (frame_tick) begin
                  if (dist_in <= STEP_X) begin
                     base_x   <= TGT_X;
                     hold_cnt <= '0;
                     visible  <= 1'b1;
                     state    <= S_HOLD;
`ifdef BANNER_BLINK_EN
                     blink_cnt <= '0;
`endif
                  end else begin
                     base_x <= base_x - STEP_X;
                  end
               end
            end

            S_HOLD: begin
               if (abort) begin
                  state   <= S_SCROLL_OUT;
                  visible <= 1'b1;
               end else if (frame_tick) begin
                  if (hold_cnt == HOLD_LAST) begin
                     state   <= S_SCROLL_OUT;
                     visible <= 1'b1;
                  end else begin
                     hold_cnt <= hold_cnt + HOLD_W'(1);
`ifdef BANNER_BLINK_EN
                     if (blink_cnt == BLINK_LAST) begin
                        blink_cnt <= '0;
                        visible   <= ~visible;
                     end else begin
                        blink_cnt <= blink_cnt + BLINK_W'(1);
                     end
`endif
                  end
               end
            end

            S_SCROLL_OUT: begin
               if (frame_tick) begin
                  if (dist_out <= STEP_X) begin
                     base_x  <= SCR_X;
                     visible <= 1'b0;
                     state   <= S_IDLE;
                     done    <= 1'b1;
                  end else begin
                     base_x <= base_x + STEP_X;
                  end
               end
            end

            default: begin
               state   <= S_IDLE;
               base_x  <= SCR_X;
               visible <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_banner_scroll_ctrl.sv
// Directed bench for banner_scroll_ctrl with default parameters; blink expectations follow BANNER_BLINK_EN.
module tb_banner_scroll_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       frame_tick;
   logic       start;
   logic       abort;
   logic [3:0] glyph_on;
   logic [9:0] base_x;
   logic [9:0] base_y;
   logic       display;
   logic       busy;
   logic       done;

   int n_cmp = 0;
   int n_err = 0;

   banner_scroll_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .start      (start),
      .abort      (abort),
      .glyph_on   (glyph_on),
      .base_x     (base_x),
      .base_y     (base_y),
      .display    (display),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are sampled on the falling edge after the update.
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic frame();
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_in();
      pulse_start();
      repeat (49) frame();
   endtask

   task automatic test_reset();
      glyph_on = 4'b1111;
      do_reset();
      run_in();
      repeat (5) frame();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (base_x !== 10'd640) begin n_err++; $display("FAIL reset_base_x: got %0d expected 640", base_x); end
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      n_cmp++;
      if (display !== 1'b0) begin n_err++; $display("FAIL reset_display: got %0b expected 0", display); end
      n_cmp++;
      if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b expected 0", done); end
      n_cmp++;
      if (base_y !== 10'd220) begin n_err++; $display("FAIL reset_base_y: got %0d expected 220", base_y); end
   endtask

   task automatic test_scroll_in();
      logic [9:0] exp_x;
      do_reset();
      glyph_on = 4'b1111;
      pulse_start();
      n_cmp++;
      if (busy !== 1'b1 || display !== 1'b1 || base_x !== 10'd640) begin
         n_err++;
         $display("FAIL start_accept: got busy=%0b display=%0b x=%0d expected busy=1 display=1 x=640", busy, display, base_x);
      end
      repeat (3) cyc();
      n_cmp++;
      if (base_x !== 10'd640) begin n_err++; $display("FAIL no_tick_hold: got %0d expected 640", base_x); end
      for (int k = 1; k <= 49; k++) begin
         frame();
         exp_x = (k < 49) ? 10'(640 - 8 * k) : 10'd250;
         n_cmp++;
         if (base_x !== exp_x) begin n_err++; $display("FAIL scroll_in_x tick %0d: got %0d expected %0d", k, base_x, exp_x); end
      end
   endtask

   // Continues from test_scroll_in: device is in HOLD at x=250.
   task automatic test_hold_and_out();
      logic       exp_disp;
      logic [9:0] exp_x;
      glyph_on = 4'b0000;
      cyc();
      n_cmp++;
      if (display !== 1'b0) begin n_err++; $display("FAIL glyph_gate: got %0b expected 0", display); end
      glyph_on = 4'b0010;
      for (int k = 1; k <= 119; k++) begin
         frame();
`ifdef BANNER_BLINK_EN
         exp_disp = ((k / 15) % 2) == 0;
`else
         exp_disp = 1'b1;
`endif
         n_cmp++;
         if (base_x !== 10'd250 || display !== exp_disp || busy !== 1'b1) begin
            n_err++;
            $display("FAIL hold tick %0d: got x=%0d display=%0b busy=%0b expected x=250 display=%0b busy=1", k, base_x, display, busy, exp_disp);
         end
      end
      frame();
      n_cmp++;
      if (base_x !== 10'd250 || display !== 1'b1) begin
         n_err++;
         $display("FAIL hold_exit: got x=%0d display=%0b expected x=250 display=1", base_x, display);
      end
      for (int k = 1; k <= 49; k++) begin
         frame();
         exp_x = (k < 49) ? 10'(250 + 8 * k) : 10'd640;
         n_cmp++;
         if (base_x !== exp_x || done !== (k == 49) || busy !== (k != 49)) begin
            n_err++;
            $display("FAIL scroll_out tick %0d: got x=%0d done=%0b busy=%0b expected x=%0d done=%0b busy=%0b",
                     k, base_x, done, busy, exp_x, (k == 49), (k != 49));
         end
      end
      n_cmp++;
      if (display !== 1'b0) begin n_err++; $display("FAIL out_display: got %0b expected 0", display); end
      cyc();
      n_cmp++;
      if (done !== 1'b0) begin n_err++; $display("FAIL done_width: got %0b expected 0", done); end
   endtask

   task automatic test_abort_hold();
      logic [9:0] exp_x;
      do_reset();
      glyph_on = 4'b0100;
      run_in();
      repeat (10) frame();
      abort = 1'b1;
      frame();
      abort = 1'b0;
      n_cmp++;
      if (base_x !== 10'd250 || display !== 1'b1 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL abort_hold: got x=%0d display=%0b busy=%0b expected x=250 display=1 busy=1", base_x, display, busy);
      end
      for (int k = 1; k <= 49; k++) begin
         frame();
         exp_x = (k < 49) ? 10'(250 + 8 * k) : 10'd640;
         n_cmp++;
         if (base_x !== exp_x || done !== (k == 49)) begin
            n_err++;
            $display("FAIL abort_out tick %0d: got x=%0d done=%0b expected x=%0d done=%0b", k, base_x, done, exp_x, (k == 49));
         end
      end
   endtask

   task automatic test_abort_scroll_in();
      do_reset();
      pulse_start();
      repeat (5) frame();
      abort = 1'b1;
      frame();
      abort = 1'b0;
      n_cmp++;
      if (base_x !== 10'd600) begin n_err++; $display("FAIL abort_in_x: got %0d expected 600", base_x); end
      frame();
      n_cmp++;
      if (base_x !== 10'd608) begin n_err++; $display("FAIL abort_in_dir: got %0d expected 608", base_x); end
   endtask

   task automatic test_start_abort_idle();
      do_reset();
      glyph_on = 4'b1111;
      start = 1'b1;
      abort = 1'b1;
      cyc();
      start = 1'b0;
      abort = 1'b0;
      frame();
      n_cmp++;
      if (busy !== 1'b0 || base_x !== 10'd640 || display !== 1'b0) begin
         n_err++;
         $display("FAIL start_abort_idle: got busy=%0b x=%0d display=%0b expected busy=0 x=640 display=0", busy, base_x, display);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      pulse_start();
      repeat (3) frame();
      pulse_start();
      frame();
      n_cmp++;
      if (base_x !== 10'd608) begin n_err++; $display("FAIL restart_ignored: got %0d expected 608", base_x); end
   endtask

   initial begin
      reset      = 1'b1;
      frame_tick = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      glyph_on   = 4'b0000;
      test_reset();
      test_scroll_in();
      test_hold_and_out();
      test_abort_hold();
      test_abort_scroll_in();
      test_start_abort_idle();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
